fifo_transaction_gen: RTL and testbench

//  Synthesizable random-stimulus generator for the synchronous FIFO. Emits one FIFO transaction per clock.

---
 rtl/fifo_transaction_pkg.sv | 31 +++
 rtl/fifo_txn_lfsr.sv | 47 ++++
 rtl/fifo_transaction_gen.sv | 142 ++++++++++++++
 tb/tb_fifo_transaction_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_transaction_pkg.sv
// Shared constants, types and threshold helper for the FIFO transaction generator.
package fifo_transaction_pkg;

    localparam int unsigned LFSR_W     = 32;
    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam logic [31:0] SEED_A_RST = 32'h0000_0001;
    localparam logic [31:0] SEED_B_RST = 32'hA5A5_5A5A;
    localparam logic [31:0] SEED_B_XOR = 32'hA5A5_5A5A;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic rst_n;
        logic wr_en;
        logic rd_en;
    } txn_ctl_t;

    // Percentage to 8-bit compare threshold; 100% saturates at 255.
    function automatic logic [7:0] thr(input int unsigned pct);
        int unsigned t;
        t = (pct * 256) / 100;
        if (t > 255) begin
            t = 255;
        end
        return 8'(t);
    endfunction

endpackage

// File: rtl/fifo_txn_lfsr.sv
// 32-bit Galois LFSR with seed load, step enable and an all-zero guard.
module fifo_txn_lfsr
    import fifo_transaction_pkg::*;
#(
    parameter logic [31:0] RST_VAL = 32'h0000_0001,
    parameter int unsigned OUT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [31:0]      load_val_i,
    output logic [OUT_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;
    logic [LFSR_W-1:0] stepped;

    // Load beats step; a zero state would lock the LFSR, so it is forced to 1.
    always_comb begin
        stepped = state_q >> 1;
        if (state_q[0]) begin
            stepped = stepped ^ LFSR_POLY;
        end
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (step_i) begin
            state_d = stepped;
        end
        if (state_d == '0) begin
            state_d = 32'h0000_0001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/fifo_transaction_gen.sv
// Weighted-random FIFO transaction generator: one transaction per clock for NUM_TXN cycles.
module fifo_transaction_gen
    import fifo_transaction_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned NUM_TXN       = 1000,
    parameter int unsigned WR_EN_ON_DIST = 70,
    parameter int unsigned RD_EN_ON_DIST = 30,
    parameter int unsigned RST_ON_DIST   = 2,
    localparam int unsigned CNT_W        = $clog2(NUM_TXN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_load,
    input  logic [31:0]           seed,
    input  logic                  start,
    output logic                  txn_valid,
    output logic                  txn_rst_n,
    output logic [FIFO_WIDTH-1:0] txn_data_in,
    output logic                  txn_wr_en,
    output logic                  txn_rd_en,
    output logic [CNT_W-1:0]      txn_count,
    output logic                  busy,
    output logic                  done
);

    localparam logic [7:0] WR_THR  = thr(WR_EN_ON_DIST);
    localparam logic [7:0] RD_THR  = thr(RD_EN_ON_DIST);
    localparam logic [7:0] RST_THR = thr(RST_ON_DIST);
    localparam int unsigned B_W    = 24;

    if (FIFO_WIDTH < 1 || FIFO_WIDTH > 32 || FIFO_DEPTH < 1) begin : g_bad_params
        $error("fifo_transaction_gen: unsupported FIFO_WIDTH/FIFO_DEPTH");
    end

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    txn_ctl_t              ctl_q, ctl_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  idle_c;
    logic                  load_c;
    logic                  start_c;
    logic [FIFO_WIDTH-1:0] lfsr_a;
    logic [B_W-1:0]        lfsr_b;

    assign idle_c  = (state_q == ST_IDLE);
    assign load_c  = idle_c && seed_load;
    assign start_c = idle_c && start && !seed_load;

    fifo_txn_lfsr #(
        .RST_VAL (SEED_A_RST),
        .OUT_W   (FIFO_WIDTH)
    ) u_lfsr_a (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_c),
        .step_i     (busy_q),
        .load_val_i (seed),
        .state_o    (lfsr_a)
    );

    fifo_txn_lfsr #(
        .RST_VAL (SEED_B_RST),
        .OUT_W   (B_W)
    ) u_lfsr_b (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_c),
        .step_i     (busy_q),
        .load_val_i (seed ^ SEED_B_XOR),
        .state_o    (lfsr_b)
    );

    // RUN issues a transaction every cycle until NUM_TXN are out, then retires to IDLE with done.
    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        data_d  = data_q;
        ctl_d   = '{rst_n: 1'b1, wr_en: 1'b0, rd_en: 1'b0};
        count_d = count_q;
        done_d  = done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (count_q == CNT_W'(NUM_TXN)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    valid_d     = 1'b1;
                    data_d      = lfsr_a;
                    ctl_d.wr_en = (lfsr_b[7:0] < WR_THR);
                    ctl_d.rd_en = (lfsr_b[15:8] < RD_THR);
                    ctl_d.rst_n = !(lfsr_b[23:16] < RST_THR);
                    count_d     = CNT_W'(count_q + 1'b1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ctl_q   <= '{rst_n: 1'b0, wr_en: 1'b0, rd_en: 1'b0};
            count_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ctl_q   <= ctl_d;
            count_q <= count_d;
        end
    end

    assign txn_valid   = valid_q;
    assign txn_rst_n   = ctl_q.rst_n;
    assign txn_data_in = data_q;
    assign txn_wr_en   = ctl_q.wr_en;
    assign txn_rd_en   = ctl_q.rd_en;
    assign txn_count   = count_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fifo_transaction_gen.sv
// Self-checking bench for fifo_transaction_gen: directed first-transaction table plus full-run sequences.
module tb_fifo_transaction_gen;

    localparam int unsigned W   = 16;
    localparam int unsigned N   = 1000;
    localparam int unsigned CW  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          seed_load = 1'b0;
    logic [31:0]   seed = 32'h0;
    logic          start = 1'b0;
    logic          txn_valid;
    logic          txn_rst_n;
    logic [W-1:0]  txn_data_in;
    logic          txn_wr_en;
    logic          txn_rd_en;
    logic [CW-1:0] txn_count;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rs_cnt = 0;
    logic [18:0] seq [4][N];

    typedef struct {
        logic [31:0] seed;
        logic [15:0] d1;
        logic        w1, r1, n1;
        logic [15:0] d2;
        logic        w2, r2, n2;
    } vec_t;

    vec_t vecs [5];

    fifo_transaction_gen #(
        .FIFO_WIDTH    (W),
        .FIFO_DEPTH    (8),
        .NUM_TXN       (N),
        .WR_EN_ON_DIST (70),
        .RD_EN_ON_DIST (30),
        .RST_ON_DIST   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seed_load   (seed_load),
        .seed        (seed),
        .start       (start),
        .txn_valid   (txn_valid),
        .txn_rst_n   (txn_rst_n),
        .txn_data_in (txn_data_in),
        .txn_wr_en   (txn_wr_en),
        .txn_rd_en   (txn_rd_en),
        .txn_count   (txn_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic logic [31:0] gstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] nz(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    // Full run against an independent LFSR model; optional busy-time control pulses or mid-run abort.
    task automatic run_full(input logic [31:0] s, input int r, input bit inject, input bit abort);
        logic [31:0] a, b;
        logic [18:0] e_txn;
        logic [18:0] a_txn;
        int n;
        int cyc;
        a = nz(s);
        b = nz(s ^ 32'hA5A5_5A5A);
        seed = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("run%0d_start", r), {busy, txn_valid, done, txn_count}, {1'b1, 1'b0, 1'b0, 10'd0});
        n = 0;
        cyc = 0;
        while (n < N && cyc < N + 200) begin
            tick();
            cyc++;
            seed_load = 1'b0;
            start = 1'b0;
            if (txn_valid) begin
                n++;
                e_txn = {a[15:0], b[7:0] < 8'd179, b[15:8] < 8'd76, !(b[23:16] < 8'd5)};
                a_txn = {txn_data_in, txn_wr_en, txn_rd_en, txn_rst_n};
                check($sformatf("run%0d_txn%0d", r, n), {a_txn, txn_count}, {e_txn, CW'(n)});
                seq[r][n-1] = a_txn;
                if (r == 0) begin
                    wr_cnt += int'(txn_wr_en);
                    rd_cnt += int'(txn_rd_en);
                    rs_cnt += int'(!txn_rst_n);
                end
                a = gstep(a);
                b = gstep(b);
                if (inject && n == 100) begin
                    seed = 32'hDEAD_BEEF;
                    seed_load = 1'b1;
                    start = 1'b1;
                end
                if (abort && n == 500) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    check("abort_at_500", {busy, done, txn_valid, txn_rst_n, txn_count},
                          {1'b0, 1'b0, 1'b0, 1'b0, 10'd0});
                    tick();
                    check("abort_idle", {busy, done, txn_valid, txn_rst_n}, {1'b0, 1'b0, 1'b0, 1'b1});
                    return;
                end
            end
        end
        check($sformatf("run%0d_valid_cycles", r), 64'(n), 64'(N));
        tick();
        check($sformatf("run%0d_end", r), {busy, done, txn_valid, txn_count}, {1'b0, 1'b1, 1'b0, 10'd1000});
        tick();
        tick();
        tick();
        check($sformatf("run%0d_done_hold", r),
              {busy, done, txn_valid, txn_wr_en, txn_rd_en, txn_rst_n, txn_count, txn_data_in},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1000, seq[r][N-1][18:3]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int diffs;
        vecs[0] = '{32'h1234_5678, 16'h5678, 1'b1, 1'b1, 1'b1, 16'h2B3C, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_0000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'hA5A5_5A5A, 16'h5A5A, 1'b1, 1'b1, 1'b0, 16'hAD2D, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_00A5, 16'h00A5, 1'b0, 1'b0, 1'b1, 16'h0051, 1'b1, 1'b0, 1'b1};

        // Reset values, then idle drive once released.
        rst = 1'b1;
        tick();
        tick();
        check("reset", {txn_valid, txn_rst_n, txn_data_in, txn_wr_en, txn_rd_en, txn_count, busy, done}, 64'h0);
        rst = 1'b0;
        tick();
        check("post_reset_idle", {txn_valid, txn_rst_n, txn_wr_en, txn_rd_en, busy, done},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        // seed_load and start together: load wins, no run starts.
        seed = 32'h1234_5678;
        seed_load = 1'b1;
        start = 1'b1;
        tick();
        seed_load = 1'b0;
        start = 1'b0;
        tick();
        check("load_beats_start", {busy, txn_valid}, {1'b0, 1'b0});

        // First two transactions for directed seeds.
        for (int i = 0; i < 5; i++) begin
            seed = vecs[i].seed;
            seed_load = 1'b1;
            tick();
            seed_load = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            check($sformatf("vec%0d_txn1", i), {txn_valid, txn_data_in, txn_wr_en, txn_rd_en, txn_rst_n, txn_count},
                  {1'b1, vecs[i].d1, vecs[i].w1, vecs[i].r1, vecs[i].n1, 10'd1});
            tick();
            check($sformatf("vec%0d_txn2", i), {txn_valid, txn_data_in, txn_wr_en, txn_rd_en, txn_rst_n, txn_count},
                  {1'b1, vecs[i].d2, vecs[i].w2, vecs[i].r2, vecs[i].n2, 10'd2});
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
        end

        run_full(32'h1234_5678, 0, 1'b0, 1'b0);
        check_range("dist_wr_en", wr_cnt, 640, 760);
        check_range("dist_rd_en", rd_cnt, 250, 350);
        check_range("dist_fifo_rst", rs_cnt, 5, 35);

        run_full(32'h1234_5678, 1, 1'b1, 1'b0);
        diffs = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (seq[0][i] !== seq[1][i]) diffs++;
        end
        check("determinism_diffs", 64'(diffs), 64'd0);

        run_full(32'h0000_0000, 2, 1'b0, 1'b0);
        check("zero_seed_first_data", 64'(seq[2][0][18:3]), 64'h0001);

        run_full(32'h0BAD_F00D, 3, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
